// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   - MIPS load/store opcode constants (Instr[31:26])
//   - store-data forward select encodings
//   - decoded memory-operation descriptor and its decode function
package mem_stage_pkg;

  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLhu = 6'b100101;
  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpSw  = 6'b101011;
  localparam logic [5:0] OpSh  = 6'b101001;
  localparam logic [5:0] OpSb  = 6'b101000;

  // Trans_DMIn_Sel encodings
  localparam logic TransSelRData2 = 1'b0;
  localparam logic TransSelWData  = 1'b1;

  typedef enum logic [1:0] {
    SizeNone,
    SizeByte,
    SizeHalf,
    SizeWord
  } mem_size_e;

  typedef struct packed {
    logic      load;
    logic      store;
    logic      sext;
    mem_size_e size;
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [5:0] opcode);
    mem_op_t op;
    op = '{load: 1'b0, store: 1'b0, sext: 1'b0, size: SizeNone};
    case (opcode)
      OpLw:    op = '{load: 1'b1, store: 1'b0, sext: 1'b0, size: SizeWord};
      OpLh:    op = '{load: 1'b1, store: 1'b0, sext: 1'b1, size: SizeHalf};
      OpLhu:   op = '{load: 1'b1, store: 1'b0, sext: 1'b0, size: SizeHalf};
      OpLb:    op = '{load: 1'b1, store: 1'b0, sext: 1'b1, size: SizeByte};
      OpLbu:   op = '{load: 1'b1, store: 1'b0, sext: 1'b0, size: SizeByte};
      OpSw:    op = '{load: 1'b0, store: 1'b1, sext: 1'b0, size: SizeWord};
      OpSh:    op = '{load: 1'b0, store: 1'b1, sext: 1'b0, size: SizeHalf};
      OpSb:    op = '{load: 1'b0, store: 1'b1, sext: 1'b0, size: SizeByte};
      default: op = '{load: 1'b0, store: 1'b0, sext: 1'b0, size: SizeNone};
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_stage_dm_ram.sv
// Data memory word array for the MEM stage.
//   clk_i    : write clock (rising edge)
//   rst_ni   : asynchronous active-low clear of every word
//   be_i     : per-byte write enables, little-endian lanes (bit b -> bits 8b+7:8b)
//   addr_i   : word index, shared by read and write
//   wdata_i  : lane-aligned write data
//   rdata_o  : asynchronous read of the addressed word
module mem_stage_dm_ram #(
  parameter int unsigned AddrWidth = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [3:0]           be_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  localparam int unsigned Depth = 1 << AddrWidth;

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline plus the MEM/WB pipeline register.
// Decodes the load/store in Instr_M, forwards store data from W when selected,
// performs byte-enabled stores and extended loads on the data memory, and
// registers every M->W field (1-cycle latency).
// Ports:
//   clk, reset_n (async, active-low)
//   Instr_M, PC_M, ALUResult_M (address), RData2_M, W_GRFWData, Trans_DMIn_Sel,
//   WriteA_M, RegWrite_M                                        -- M-stage inputs
//   Instr_W, PC_W, ALUResult_W, DMRData_W, WriteA_W, RegWrite_W, AdErr_W -- W outputs
// Optional macro DM_MONITOR_EN: print every committed store (time, PC, word address, merged word).
module mem_stage
  import mem_stage_pkg::*;
#(
  // Must stay <= 29 so the out-of-range check has at least one high address bit.
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Instr_M,
  input  logic [31:0] PC_M,
  input  logic [31:0] ALUResult_M,
  input  logic [31:0] RData2_M,
  input  logic [31:0] W_GRFWData,
  input  logic        Trans_DMIn_Sel,
  input  logic [4:0]  WriteA_M,
  input  logic        RegWrite_M,
  output logic [31:0] Instr_W,
  output logic [31:0] PC_W,
  output logic [31:0] ALUResult_W,
  output logic [31:0] DMRData_W,
  output logic [4:0]  WriteA_W,
  output logic        RegWrite_W,
  output logic        AdErr_W
);

  mem_op_t               op;
  logic [1:0]            offset;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  range_err;
  logic                  align_err;
  logic                  ad_err;
  logic                  mem_we;
  logic [31:0]           store_data;
  logic [31:0]           lane_wdata;
  logic [3:0]            byte_en;
  logic [31:0]           ram_rdata;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [31:0]           load_data;

  assign op       = decode_op(Instr_M[31:26]);
  assign offset   = ALUResult_M[1:0];
  assign word_idx = ALUResult_M[DEPTH_LOG2+1:2];

  assign store_data = (Trans_DMIn_Sel == TransSelWData) ? W_GRFWData : RData2_M;

  // Address error: any address bit above the array, or natural misalignment.
  assign range_err = |ALUResult_M[31:DEPTH_LOG2+2];

  always_comb begin
    align_err = 1'b0;
    unique case (op.size)
      SizeWord: align_err = (offset != 2'b00);
      SizeHalf: align_err = offset[0];
      default:  align_err = 1'b0;
    endcase
  end

  assign ad_err = (op.load | op.store) & (range_err | align_err);
  assign mem_we = op.store & ~ad_err;

  // Replicate the narrow store data across all lanes; byte enables pick the lane.
  always_comb begin
    byte_en    = 4'b0000;
    lane_wdata = store_data;
    unique case (op.size)
      SizeWord: byte_en = 4'b1111;
      SizeHalf: begin
        byte_en    = offset[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{store_data[15:0]}};
      end
      SizeByte: begin
        byte_en    = 4'b0001 << offset;
        lane_wdata = {4{store_data[7:0]}};
      end
      default: byte_en = 4'b0000;
    endcase
    if (!mem_we) begin
      byte_en = 4'b0000;
    end
  end

  mem_stage_dm_ram #(
    .AddrWidth(DEPTH_LOG2)
  ) u_dm_ram (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .be_i   (byte_en),
    .addr_i (word_idx),
    .wdata_i(lane_wdata),
    .rdata_o(ram_rdata)
  );

  assign lane_byte = ram_rdata[{offset, 3'b000} +: 8];
  assign lane_half = offset[1] ? ram_rdata[31:16] : ram_rdata[15:0];

  always_comb begin
    load_data = '0;
    if (op.load && !ad_err) begin
      unique case (op.size)
        SizeWord: load_data = ram_rdata;
        SizeHalf: load_data = op.sext ? {{16{lane_half[15]}}, lane_half} : {16'h0000, lane_half};
        SizeByte: load_data = op.sext ? {{24{lane_byte[7]}}, lane_byte} : {24'h000000, lane_byte};
        default:  load_data = '0;
      endcase
    end
  end

  // MEM/WB pipeline register
  logic [31:0] instr_d, instr_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] alu_result_d, alu_result_q;
  logic [31:0] dm_rdata_d, dm_rdata_q;
  logic [4:0]  write_a_d, write_a_q;
  logic        reg_write_d, reg_write_q;
  logic        ad_err_d, ad_err_q;

  always_comb begin
    instr_d      = Instr_M;
    pc_d         = PC_M;
    alu_result_d = ALUResult_M;
    dm_rdata_d   = load_data;
    write_a_d    = WriteA_M;
    reg_write_d  = RegWrite_M;
    ad_err_d     = ad_err;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q      <= '0;
      pc_q         <= '0;
      alu_result_q <= '0;
      dm_rdata_q   <= '0;
      write_a_q    <= '0;
      reg_write_q  <= 1'b0;
      ad_err_q     <= 1'b0;
    end else begin
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      alu_result_q <= alu_result_d;
      dm_rdata_q   <= dm_rdata_d;
      write_a_q    <= write_a_d;
      reg_write_q  <= reg_write_d;
      ad_err_q     <= ad_err_d;
    end
  end

  assign Instr_W     = instr_q;
  assign PC_W        = pc_q;
  assign ALUResult_W = alu_result_q;
  assign DMRData_W   = dm_rdata_q;
  assign WriteA_W    = write_a_q;
  assign RegWrite_W  = reg_write_q;
  assign AdErr_W     = ad_err_q;

`ifdef DM_MONITOR_EN
  logic [31:0] be_mask;
  logic [31:0] merged_word;

  always_comb begin
    be_mask     = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
    merged_word = (ram_rdata & ~be_mask) | (lane_wdata & be_mask);
  end

  always @(posedge clk) begin
    if (reset_n && mem_we) begin
      $display("%d@%h: *%h <= %h", $time, PC_M, {ALUResult_M[31:2], 2'b00}, merged_word);
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// load/store/other traffic checked against a byte-addressed memory model.
module tb_mem_stage;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr_m, pc_m, alu_m, rdata2_m, w_wdata;
  logic        trans_sel;
  logic [4:0]  write_a_m;
  logic        reg_write_m;
  logic [31:0] instr_w, pc_w, alu_w, dmr_w;
  logic [4:0]  write_a_w;
  logic        reg_write_w, aderr_w;

  int tests = 0;
  int fails = 0;

  // Reference memory: 4 KiB of bytes, little-endian.
  logic [7:0] ref_mem [4096];

  mem_stage dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .Instr_M       (instr_m),
    .PC_M          (pc_m),
    .ALUResult_M   (alu_m),
    .RData2_M      (rdata2_m),
    .W_GRFWData    (w_wdata),
    .Trans_DMIn_Sel(trans_sel),
    .WriteA_M      (write_a_m),
    .RegWrite_M    (reg_write_m),
    .Instr_W       (instr_w),
    .PC_W          (pc_w),
    .ALUResult_W   (alu_w),
    .DMRData_W     (dmr_w),
    .WriteA_W      (write_a_w),
    .RegWrite_W    (reg_write_w),
    .AdErr_W       (aderr_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
  endtask

  // Behavioural view: an access of N bytes at byte address A.
  task automatic model(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                       output logic [31:0] ld_val, output logic err);
    bit ld, st, sx;
    int size;
    logic [31:0] v;
    ld = 0; st = 0; sx = 0; size = 1;
    case (op)
      6'b100011: begin ld = 1; size = 4; end
      6'b100001: begin ld = 1; size = 2; sx = 1; end
      6'b100101: begin ld = 1; size = 2; end
      6'b100000: begin ld = 1; size = 1; sx = 1; end
      6'b100100: begin ld = 1; size = 1; end
      6'b101011: begin st = 1; size = 4; end
      6'b101001: begin st = 1; size = 2; end
      6'b101000: begin st = 1; size = 1; end
      default: ;
    endcase
    err = (ld || st) && (((addr % size) != 0) || (addr >= 32'd4096));
    v = 32'h0;
    if (ld && !err) begin
      for (int i = 0; i < size; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
      if (sx && size < 4 && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
    end
    if (st && !err) begin
      for (int i = 0; i < size; i++) ref_mem[addr + i] = 8'(sdata >> (8 * i));
    end
    ld_val = v;
  endtask

  // One instruction through M; checks every W field one cycle later.
  task automatic step(input string tag, input logic [5:0] op, input logic [31:0] addr,
                      input logic [31:0] rd2, input logic [31:0] fwd, input logic sel);
    logic [31:0] r, instr, pc, exp_ld;
    logic [4:0]  wa;
    logic        rw, exp_err;
    r = $urandom();
    instr = {op, r[25:0]};
    pc = $urandom();
    r = $urandom();
    wa = r[4:0];
    rw = r[5];
    model(op, addr, sel ? fwd : rd2, exp_ld, exp_err);
    instr_m = instr; pc_m = pc; alu_m = addr; rdata2_m = rd2; w_wdata = fwd;
    trans_sel = sel; write_a_m = wa; reg_write_m = rw;
    @(posedge clk);
    #1;
    check({tag, "_instr"}, instr_w, instr);
    check({tag, "_pc"}, pc_w, pc);
    check({tag, "_alu"}, alu_w, addr);
    check({tag, "_dmr"}, dmr_w, exp_ld);
    check({tag, "_aderr"}, {31'h0, aderr_w}, {31'h0, exp_err});
    check({tag, "_wa"}, {27'h0, write_a_w}, {27'h0, wa});
    check({tag, "_rw"}, {31'h0, reg_write_w}, {31'h0, rw});
  endtask

  task automatic check_w_zero(input string tag);
    check({tag, "_instr"}, instr_w, 32'h0);
    check({tag, "_pc"}, pc_w, 32'h0);
    check({tag, "_alu"}, alu_w, 32'h0);
    check({tag, "_dmr"}, dmr_w, 32'h0);
    check({tag, "_wa"}, {27'h0, write_a_w}, 32'h0);
    check({tag, "_rw"}, {31'h0, reg_write_w}, 32'h0);
    check({tag, "_aderr"}, {31'h0, aderr_w}, 32'h0);
  endtask

  localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101, LB = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100, SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;
  localparam logic [5:0] ADDU = 6'b000000, ORI = 6'b001101;

  initial begin
    logic [5:0]  ops [10];
    logic [31:0] addr;
    int          sel_r;
    ops = '{LW, LH, LHU, LB, LBU, SW, SH, SB, ADDU, ORI};

    reset_n = 1'b0;
    instr_m = '0; pc_m = '0; alu_m = '0; rdata2_m = '0; w_wdata = '0;
    trans_sel = 1'b0; write_a_m = '0; reg_write_m = 1'b0;
    clear_model();
    #12;
    check_w_zero("reset");
    reset_n = 1'b1;

    // Word store then byte/word loads
    step("t2_sw", SW, 32'h10, 32'h12345678, 32'h0, 1'b0);
    step("t2_lb13", LB, 32'h13, 32'h0, 32'h0, 1'b0);
    check("t2_lb13_const", dmr_w, 32'h00000012);
    step("t2_lb10", LB, 32'h10, 32'h0, 32'h0, 1'b0);
    check("t2_lb10_const", dmr_w, 32'h00000078);
    step("t2_lw", LW, 32'h10, 32'h0, 32'h0, 1'b0);
    check("t2_lw_const", dmr_w, 32'h12345678);

    // Byte store into empty word; sign vs zero extension
    step("t3_sb", SB, 32'h21, 32'hFFFF_FF80, 32'h0, 1'b0);
    step("t3_lw", LW, 32'h20, 32'h0, 32'h0, 1'b0);
    check("t3_lw_const", dmr_w, 32'h00008000);
    step("t3_lb", LB, 32'h21, 32'h0, 32'h0, 1'b0);
    check("t3_lb_const", dmr_w, 32'hFFFFFF80);
    step("t3_lbu", LBU, 32'h21, 32'h0, 32'h0, 1'b0);
    check("t3_lbu_const", dmr_w, 32'h00000080);

    // Halfword store/load; misaligned halfword store is suppressed
    step("t4_sh", SH, 32'h32, 32'h1234_BEEF, 32'h0, 1'b0);
    step("t4_lh", LH, 32'h32, 32'h0, 32'h0, 1'b0);
    check("t4_lh_const", dmr_w, 32'hFFFFBEEF);
    step("t4_lhu", LHU, 32'h32, 32'h0, 32'h0, 1'b0);
    check("t4_lhu_const", dmr_w, 32'h0000BEEF);
    step("t4_sh_mis", SH, 32'h31, 32'h0000_5555, 32'h0, 1'b0);
    check("t4_sh_mis_aderr", {31'h0, aderr_w}, 32'h1);
    step("t4_lw", LW, 32'h30, 32'h0, 32'h0, 1'b0);
    check("t4_lw_const", dmr_w, 32'hBEEF0000);

    // Store data forwarded from W
    step("t5_sw", SW, 32'h40, 32'h0, 32'hCAFEF00D, 1'b1);
    step("t5_lw", LW, 32'h40, 32'h0, 32'h0, 1'b0);
    check("t5_lw_const", dmr_w, 32'hCAFEF00D);

    // Non-memory instruction
    step("t6_addu", ADDU, 32'hDEAD, 32'hFFFF_FFFF, 32'h0, 1'b0);
    check("t6_alu_const", alu_w, 32'h0000DEAD);
    check("t6_dmr_const", dmr_w, 32'h0);
    step("t6_lw", LW, 32'hDEAC & 32'h0FFC, 32'h0, 32'h0, 1'b0);

    // Reset asserted mid-store: outputs clear at once, store lost, memory cleared
    instr_m = {SW, 26'h0}; alu_m = 32'h10; rdata2_m = 32'hFFFF_FFFF; trans_sel = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check_w_zero("t1_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_model();
    step("t1_lw0", LW, 32'h0, 32'h0, 32'h0, 1'b0);
    check("t1_lw0_const", dmr_w, 32'h0);
    step("t1_lw10", LW, 32'h10, 32'h0, 32'h0, 1'b0);
    check("t1_lw10_const", dmr_w, 32'h0);

    // Random traffic concentrated on a small window so loads hit prior stores
    for (int n = 0; n < 300; n++) begin
      sel_r = $urandom_range(0, 15);
      if (sel_r == 0) addr = $urandom();
      else if (sel_r == 1) addr = 32'h1000 + $urandom_range(0, 15);
      else addr = $urandom_range(0, 63);
      step("rnd", ops[$urandom_range(0, 9)], addr, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
